// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between instruction
// fetch (read-only) and the data stage. Data requests win arbitration; each
// transaction is held on the bus until mem_ack or until the wait counter
// reaches TIMEOUT, then a one-cycle DONE bubble issues the done pulse.
// All outputs are registered.
// Optional feature macro: MEM_ARB_STARVE_EN (fetch anti-starvation after
// STARVE_MAX consecutive data grants made while if_req is pending).
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic [1:0]        d_command,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              bus_err,
    output logic [1:0]        mem_command,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    // Last wait-count value before the abort; the counter holds the number of
    // BUSY cycles already elapsed, so the abort lands on the TIMEOUT-th one.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
        $error("mem_bus_arbiter: TIMEOUT must be in 1..65535");
    end
    if (STARVE_MAX < 1) begin : g_chk_starve
        $error("mem_bus_arbiter: STARVE_MAX must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [15:0]       wait_cnt, wait_cnt_nxt;
    logic [1:0]        cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, if_rdata_nxt, d_rdata_nxt, rdata_cap;
    logic              if_done_nxt, d_done_nxt, err_nxt;
    logic              d_valid, wait_over, force_if;

    assign d_valid   = (d_command == BUS_LOAD) || (d_command == BUS_STORE);
    assign wait_over = (wait_cnt == WAIT_LAST);
    // Stores return no data; aborted transactions return zero.
    assign rdata_cap = (mem_ack && mem_command != BUS_STORE) ? mem_rdata : '0;

`ifdef MEM_ARB_STARVE_EN
    localparam int              SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt, starve_nxt;

    assign force_if = if_req && (starve_cnt == SMAX);

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt <= '0;
        else      starve_cnt <= starve_nxt;
    end
`else
    assign force_if = 1'b0;
`endif

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_command <= BUS_NONE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_command <= cmd_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            if_rdata    <= if_rdata_nxt;
            d_rdata     <= d_rdata_nxt;
            if_done     <= if_done_nxt;
            d_done      <= d_done_nxt;
            bus_err     <= err_nxt;
        end
    end

    // Arbitration, transaction sequencing and next values of all outputs.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        cmd_nxt      = mem_command;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        if_done_nxt  = 1'b0;
        d_done_nxt   = 1'b0;
        err_nxt      = 1'b0;
`ifdef MEM_ARB_STARVE_EN
        starve_nxt   = starve_cnt;
`endif
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (d_valid && !force_if) begin
                    cmd_nxt   = d_command;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                    state_nxt = D_BUSY;
`ifdef MEM_ARB_STARVE_EN
                    starve_nxt = if_req ? starve_cnt + 1'b1 : '0;
`endif
                end else if (if_req) begin
                    cmd_nxt   = BUS_LOAD;
                    addr_nxt  = if_addr;
                    wdata_nxt = '0;
                    state_nxt = I_BUSY;
`ifdef MEM_ARB_STARVE_EN
                    starve_nxt = '0;
`endif
                end
            end
            D_BUSY, I_BUSY: begin
                wait_cnt_nxt = wait_cnt + 16'd1;
                if (mem_ack || wait_over) begin
                    cmd_nxt   = BUS_NONE;
                    err_nxt   = !mem_ack;
                    state_nxt = DONE;
                    if (state == D_BUSY) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = rdata_cap;
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = rdata_cap;
                    end
                end
            end
            DONE: begin
                wait_cnt_nxt = '0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
// Honours MEM_ARB_STARVE_EN when defined.
module tb_mem_bus_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 8;
    localparam int SMAX = 4;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] STORE = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic [1:0]    d_command = NONE;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          bus_err;
    logic [1:0]    mem_command;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int starve      = 0;   // model: consecutive data grants with fetch waiting

    mem_bus_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TO),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .d_command   (d_command),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .bus_err     (bus_err),
        .mem_command (mem_command),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner of the next arbitration: 0 none, 1 data, 2 fetch.
    function automatic int pick();
        bit dv;
        dv = (d_command == LOAD) || (d_command == STORE);
`ifdef MEM_ARB_STARVE_EN
        if (if_req && starve >= SMAX) return 2;
`endif
        if (dv) return 1;
        if (if_req) return 2;
        return 0;
    endfunction

    // Called at a negedge with the arbiter idle and requests already driven.
    // Memory acks on busy cycle ack_at (1-based); outside 1..TO means never.
    task automatic serve(input int ack_at, input logic [31:0] rd, output int w);
        logic [1:0]  ecmd;
        logic [31:0] eaddr, ewd, erd;
        logic        eerr, eif, ed;
        w = pick();
`ifdef MEM_ARB_STARVE_EN
        if (w == 2) starve = 0;
        else if (w == 1) starve = if_req ? starve + 1 : 0;
`endif
        ecmd  = (w == 1) ? d_command : ((w == 2) ? LOAD : NONE);
        eaddr = (w == 1) ? d_addr : if_addr;
        ewd   = (w == 1) ? d_wdata : 32'h0;
        mem_ack   = ($urandom_range(0, 1) == 1);   // ignored while idle
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        if (w == 0) begin
            chk("idle_no_grant", {mem_command, if_done, d_done, bus_err}, {NONE, 3'b000});
            return;
        end
        chk("grant_bus", {mem_command, mem_addr, mem_wdata}, {ecmd, eaddr, ewd});
        for (int n = 1; n <= TO; n++) begin
            mem_ack   = (n == ack_at);
            mem_rdata = (n == ack_at) ? rd : $urandom;
            if (w == 1) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else begin
                if_addr = $urandom;
            end
            @(negedge clk);
            if (n == ack_at || n == TO) break;
            chk("busy_hold", {mem_command, mem_addr, mem_wdata, if_done, d_done, bus_err},
                {ecmd, eaddr, ewd, 3'b000});
        end
        eerr = (ack_at < 1 || ack_at > TO);
        erd  = (eerr || ecmd == STORE) ? 32'h0 : rd;
        eif  = (w == 2);
        ed   = (w == 1);
        chk("done_flags", {if_done, d_done, bus_err, mem_command}, {eif, ed, eerr, NONE});
        chk("done_rdata", (w == 1) ? d_rdata : if_rdata, erd);
        if (w == 1) d_command = NONE;
        else        if_req = 1'b0;
        mem_ack   = ($urandom_range(0, 1) == 1);   // ignored in the done bubble
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("after_done", {if_done, d_done, bus_err, mem_command}, {3'b000, NONE});
    endtask

    initial begin
        int w;
        int fetches;
        int exp_w;

        // Reset with requests and ack asserted: bus stays quiet.
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h40; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); @(negedge clk);
        chk("reset_bus", {mem_command, mem_addr, mem_wdata}, {NONE, 32'h0, 32'h0});
        chk("reset_out", {if_rdata, d_rdata, if_done, d_done, bus_err}, {64'h0, 3'b000});
        rst = 1'b1; mem_ack = 1'b0; starve = 0;
        serve(1, 32'h1111_2222, w);
        chk("reset_release_fetch", w, 2);

        // Fetch with a two-cycle memory.
        if_req = 1'b1; if_addr = 32'h100;
        serve(2, 32'h0000_0013, w);
        chk("fetch_winner", w, 2);

        // Store and fetch together: store first, fetch in the next idle cycle.
        d_command = STORE; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h300;
        serve(1, 32'h5555_AAAA, w);
        chk("simul_store_first", w, 1);
        serve(3, 32'h0BAD_F00D, w);
        chk("simul_fetch_next", w, 2);

        // Load that times out, then a normal load.
        d_command = LOAD; d_addr = 32'h400;
        serve(0, 32'h1234_5678, w);
        d_command = LOAD; d_addr = 32'h404;
        serve(3, 32'hCAFE_0001, w);

        // Ack exactly on the TIMEOUT-th busy cycle: ack wins.
        d_command = LOAD; d_addr = 32'h408;
        serve(TO, 32'hA5A5_5A5A, w);
        if_req = 1'b1; if_addr = 32'h500;
        serve(TO, 32'h7777_0000, w);

        // Reset mid-transaction drops the bus at once and never signals done.
        d_command = LOAD; d_addr = 32'h600;
        @(negedge clk);
        chk("pre_abort_cmd", mem_command, LOAD);
        #2 rst = 1'b0;
        #1 chk("abort_cmd_async", mem_command, NONE);
        d_command = NONE; mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {if_done, d_done, bus_err, mem_command}, {3'b000, NONE});
        end
        mem_ack = 1'b0; rst = 1'b1; starve = 0;
        @(negedge clk);

        // Persistent load traffic with a fetch pending the whole time.
        fetches = 0;
        for (int i = 0; i < 15; i++) begin
            d_command = LOAD; d_addr = $urandom;
            if (!if_req) begin if_req = 1'b1; if_addr = $urandom; end
            serve($urandom_range(1, 3), $urandom, w);
`ifdef MEM_ARB_STARVE_EN
            exp_w = ((i % 5) == 4) ? 2 : 1;
`else
            exp_w = 1;
`endif
            chk("starve_pattern", w, exp_w);
            if (w == 2) fetches++;
        end
`ifdef MEM_ARB_STARVE_EN
        chk("starve_fetch_count", fetches, 3);
`else
        chk("starve_fetch_count", fetches, 0);
`endif
        d_command = NONE; if_req = 1'b0;

        // Randomized traffic; a losing request stays pending and unchanged.
        for (int i = 0; i < 80; i++) begin
            if (!(d_command == LOAD || d_command == STORE)) begin
                d_command = 2'($urandom_range(0, 3));
                d_addr    = $urandom;
                d_wdata   = $urandom;
            end
            if (!if_req) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = $urandom;
            end
            serve($urandom_range(1, TO + 1), $urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sits between the pipeline and memory. Sequences each transaction through an FSM until the memory acknowledges it.
- Returns per-requester done pulses, which the pipeline uses as stall-release.
- Data requests take priority over fetches. A timeout watchdog recovers from a memory that never responds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max wait cycles for mem_ack before abort (1..65535)
STARVE_MAX, 4, consecutive data grants that may be issued while if_req is pending (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
if_req  in  1  fetch request; held high with stable if_addr until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
d_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE; held stable until d_done
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse for data
bus_err  out  1  pulses with *_done when the transaction timed out
mem_command  out  2  bus command to memory
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus store data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters 0.
  - mem_command=BUS_NONE; mem_addr, mem_wdata, if_rdata and d_rdata all 0.
  - if_done, d_done and bus_err all 0.
  - Reset taken mid-transaction drops the bus command immediately. No done pulse is ever issued for the aborted transaction.
- All outputs are registered.
- FSM states: IDLE, D_BUSY, I_BUSY, DONE.
- IDLE:
  - If d_command is LOAD or STORE: latch d_addr and d_wdata onto the bus, mem_command=d_command, go to D_BUSY.
  - Else if if_req=1: mem_addr=if_addr, mem_command=BUS_LOAD, mem_wdata=0, go to I_BUSY.
  - Else stay in IDLE.
  - d_command=2'b11 is treated as BUS_NONE.
- D_BUSY / I_BUSY:
  - Bus outputs are held constant. The wait counter increments every cycle.
  - On mem_ack=1: capture mem_rdata into d_rdata or if_rdata; pulse the matching *_done the next cycle; set mem_command=BUS_NONE; go to DONE.
  - For a store, d_rdata is captured as 0.
  - If the wait counter reaches TIMEOUT with mem_ack=0: rdata=0, pulse *_done and bus_err together, set mem_command=BUS_NONE, go to DONE.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and bus_err=0.
- DONE:
  - Lasts one cycle; *_done is high during it. Clear the wait counter and return to IDLE.
  - This bubble guarantees the requester has dropped or updated its request before re-arbitration, so a done request is never re-granted.
- Latency: request seen in IDLE at cycle 0 → mem_command valid at cycle 1. If mem_ack arrives at cycle k (k≥1), *_done is high at cycle k+1.
- Minimum back-to-back period is 3 cycles (IDLE, BUSY, DONE) with zero-wait memory.
- mem_ack while in IDLE or DONE is ignored.
- Requests changed mid-transaction are ignored; the latched values are used.

Optional Feature:
- Macro: MEM_ARB_STARVE_EN.
- When defined:
  - A counter tracks consecutive data grants made while if_req=1.
  - When the counter reaches STARVE_MAX, the next IDLE arbitration grants IF even if a data request is present, then the counter clears.
  - The counter also clears on any IF grant and on reset.
- When undefined: strict data priority; the counter logic is absent.

Test Plan:
1. Reset: rst=0 with if_req=1 and mem_ack=1 → mem_command=BUS_NONE, all done pulses 0. Release rst → fetch issued the cycle after.
2. Fetch, 2-cycle memory: if_req=1, if_addr=0x100; mem_ack on 2nd BUSY cycle with mem_rdata=0x00000013 → mem_command=BUS_LOAD, mem_addr=0x100; if_done=1 with if_rdata=0x13 one cycle after ack.
3. Simultaneous requests: d_command=BUS_STORE, d_addr=0x200, d_wdata=0xDEADBEEF, together with if_req=1 → store on the bus first (mem_command=BUS_STORE); d_done, then the fetch is granted in the following IDLE cycle.
4. Timeout with TIMEOUT=8: load issued, mem_ack never asserted → d_done=1, bus_err=1, d_rdata=0 after 8 wait cycles; next request proceeds normally.
5. Ack at the timeout boundary: mem_ack on exactly the TIMEOUT-th wait cycle → bus_err=0 and rdata is captured.
6. MEM_ARB_STARVE_EN, STARVE_MAX=4: d_command continuously BUS_LOAD and if_req=1 → exactly 4 data grants, then 1 fetch grant, repeating. Without the macro the fetch is never granted.
